// File: rtl/cordic_wrapper_pkg.sv
// Shared types and the arctangent constant table for the iterative CORDIC engine.
package cordic_wrapper_pkg;

  typedef enum logic {
    CORDIC_ROTATION  = 1'b0,
    CORDIC_VECTORING = 1'b1
  } cordic_func;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

  localparam int SHIFT_W = 6;

  // atan(2^-i) as a fraction of one full turn, scaled by 2^32.
  function automatic logic [31:0] atan_turn32(input int unsigned idx);
    case (idx)
      0:  return 32'h2000_0000;
      1:  return 32'h12E4_051E;
      2:  return 32'h09FB_385B;
      3:  return 32'h0511_11D4;
      4:  return 32'h028B_0D43;
      5:  return 32'h0145_D7E1;
      6:  return 32'h00A2_F61E;
      7:  return 32'h0051_7C55;
      8:  return 32'h0028_BE53;
      9:  return 32'h0014_5F2F;
      10: return 32'h000A_2F98;
      11: return 32'h0005_17CC;
      12: return 32'h0002_8BE6;
      13: return 32'h0001_45F3;
      14: return 32'h0000_A2F9;
      15: return 32'h0000_517C;
      16: return 32'h0000_28BE;
      17: return 32'h0000_145F;
      18: return 32'h0000_0A2F;
      19: return 32'h0000_0517;
      20: return 32'h0000_028B;
      21: return 32'h0000_0145;
      22: return 32'h0000_00A2;
      23: return 32'h0000_0051;
      24: return 32'h0000_0028;
      25: return 32'h0000_0014;
      26: return 32'h0000_000A;
      27: return 32'h0000_0005;
      28: return 32'h0000_0002;
      29: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Binary-angle atan(2^-idx) rounded to nearest at the given width (width <= 32).
  function automatic logic [31:0] cordic_atan(input int unsigned idx, input int unsigned width);
    logic [32:0] acc;
    acc = {1'b0, atan_turn32(idx)};
    if (width >= 32) return acc[31:0];
    acc = acc + (33'd1 << (31 - width));
    return 32'(acc >> (32 - width));
  endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation: shift-add on x/y, arctangent step on z.
module cordic_micro_rot
  import cordic_wrapper_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  cordic_func               func_i,
  input  logic [SHIFT_W-1:0]       shift_i,
  input  logic signed [DATA_W+1:0] x_i,
  input  logic signed [DATA_W+1:0] y_i,
  input  logic [DATA_W-1:0]        z_i,
  output logic signed [DATA_W+1:0] x_o,
  output logic signed [DATA_W+1:0] y_o,
  output logic [DATA_W-1:0]        z_o
);

  logic signed [DATA_W+1:0] x_sh;
  logic signed [DATA_W+1:0] y_sh;
  logic [DATA_W-1:0]        angle;
  logic                     d_pos;

  always_comb begin
    x_sh  = x_i >>> shift_i;
    y_sh  = y_i >>> shift_i;
    angle = DATA_W'(cordic_atan(32'(shift_i), DATA_W));
    d_pos = (func_i == CORDIC_ROTATION) ? ~z_i[DATA_W-1] : y_i[DATA_W+1];
    if (d_pos) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - angle;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + angle;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: quadrant pre-rotation, then ROT_PER_CYCLE micro-rotations per clock.
//   state | meaning
//   IDLE  | waiting for an input sample
//   ITER  | micro-rotations in progress
//   DONE  | result presented, waiting for downstream
module cordic_iter_engine
  import cordic_wrapper_pkg::*;
#(
  parameter int DATA_W             = 16,
  parameter int NUM_MICRO_ROTATION = 12,
  parameter int ROT_PER_CYCLE      = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  cordic_func               i_func,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_y,
  input  logic signed [DATA_W-1:0] i_z,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W+1:0] o_x,
  output logic signed [DATA_W+1:0] o_y,
  output logic signed [DATA_W-1:0] o_z
);

  localparam int XW = DATA_W + 2;
  localparam int CW = $clog2(NUM_MICRO_ROTATION + 1);
  localparam logic [DATA_W-1:0] QUARTER  = {2'b01, {(DATA_W-2){1'b0}}};
  localparam logic [CW-1:0]     CNT_STEP = CW'(ROT_PER_CYCLE);
  localparam logic [CW-1:0]     CNT_LAST = CW'(NUM_MICRO_ROTATION - ROT_PER_CYCLE);

  if ((NUM_MICRO_ROTATION % ROT_PER_CYCLE) != 0) begin : g_bad_rot_per_cycle
    $error("ROT_PER_CYCLE must divide NUM_MICRO_ROTATION");
  end
  if (NUM_MICRO_ROTATION < 4 || NUM_MICRO_ROTATION > DATA_W || DATA_W > 32) begin : g_bad_range
    $error("NUM_MICRO_ROTATION must lie in 4..DATA_W and DATA_W must not exceed 32");
  end

  cordic_state_e      state_q, state_d;
  cordic_func         func_q, func_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0]  z_q, z_d;
  logic               in_xfer;
  logic               cnt_last;

  logic signed [XW-1:0] x_ext, y_ext, pre_x, pre_y;
  logic [DATA_W-1:0]    pre_z;

  logic signed [XW-1:0] x_c [ROT_PER_CYCLE+1];
  logic signed [XW-1:0] y_c [ROT_PER_CYCLE+1];
  logic [DATA_W-1:0]    z_c [ROT_PER_CYCLE+1];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_valid)  state_d = ST_ITER;
      ST_ITER: if (cnt_last) state_d = ST_DONE;
      ST_DONE: if (i_ready)  state_d = i_valid ? ST_ITER : ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
    o_valid = (state_q == ST_DONE);
  end

  assign in_xfer = i_valid && o_ready;

  // Fold the operand into the right half-plane so the micro-rotations converge.
  always_comb begin
    x_ext = {{2{i_x[DATA_W-1]}}, i_x};
    y_ext = {{2{i_y[DATA_W-1]}}, i_y};
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = i_z;
    if (i_func == CORDIC_ROTATION) begin
      if (i_z[DATA_W-1:DATA_W-2] == 2'b01) begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = i_z - QUARTER;
      end else if (i_z[DATA_W-1:DATA_W-2] == 2'b10) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = i_z + QUARTER;
      end
    end else begin
      if (i_x[DATA_W-1] && !i_y[DATA_W-1]) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = i_z + QUARTER;
      end else if (i_x[DATA_W-1] && i_y[DATA_W-1]) begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = i_z - QUARTER;
      end
    end
  end

  assign x_c[0] = x_q;
  assign y_c[0] = y_q;
  assign z_c[0] = z_q;

  for (genvar k = 0; k < ROT_PER_CYCLE; k++) begin : g_chain
    logic [SHIFT_W-1:0] shift;
    assign shift = SHIFT_W'(cnt_q) + SHIFT_W'(k);
    cordic_micro_rot #(.DATA_W(DATA_W)) u_micro_rot (
      .func_i  (func_q),
      .shift_i (shift),
      .x_i     (x_c[k]),
      .y_i     (y_c[k]),
      .z_i     (z_c[k]),
      .x_o     (x_c[k+1]),
      .y_o     (y_c[k+1]),
      .z_o     (z_c[k+1])
    );
  end

  always_comb begin
    func_d = func_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    if (in_xfer) begin
      func_d = i_func;
      cnt_d  = '0;
      x_d    = pre_x;
      y_d    = pre_y;
      z_d    = pre_z;
    end else if (state_q == ST_ITER) begin
      cnt_d = cnt_q + CNT_STEP;
      x_d   = x_c[ROT_PER_CYCLE];
      y_d   = y_c[ROT_PER_CYCLE];
      z_d   = z_c[ROT_PER_CYCLE];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      func_q <= CORDIC_ROTATION;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else begin
      func_q <= func_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
    end
  end

  assign o_x = x_q;
  assign o_y = y_q;
  assign o_z = z_q;

endmodule
